// File: rtl/al_accel_obuf_ctrl_if.sv
// rtl/al_accel_obuf_ctrl_if.sv - bundled ports of the output-buffer write-back controller
//
// Purpose: groups every non-clock/reset signal of al_accel_obuf_ctrl.
//   master modport : controller side (drives busy/done/ready/obuf/mem request)
//   slave  modport : environment side (drives start/cfg/sources/obuf_do/mem_ready)
// Port summary:
//   start, cfg_base[31:0], cfg_len[LEN_W-1:0]   job control
//   busy, done                                  job status
//   src0_valid/src0_data/src0_ready             result source 0
//   src1_valid/src1_data/src1_ready             result source 1
//   obuf_enb, obuf_ld_wrn, obuf_di, obuf_do     output-buffer register access
//   mem_valid, mem_addr, mem_wdata, mem_ready   memory write request
interface al_accel_obuf_ctrl_if #(
   parameter int LEN_W = 16
);
   logic             start;
   logic [31:0]      cfg_base;
   logic [LEN_W-1:0] cfg_len;
   logic             busy;
   logic             done;
   logic             src0_valid;
   logic [31:0]      src0_data;
   logic             src0_ready;
   logic             src1_valid;
   logic [31:0]      src1_data;
   logic             src1_ready;
   logic             obuf_enb;
   logic             obuf_ld_wrn;
   logic [31:0]      obuf_di;
   logic [31:0]      obuf_do;
   logic             mem_valid;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             mem_ready;

   modport master (
      input  start, cfg_base, cfg_len,
      input  src0_valid, src0_data, src1_valid, src1_data,
      input  obuf_do, mem_ready,
      output busy, done, src0_ready, src1_ready,
      output obuf_enb, obuf_ld_wrn, obuf_di,
      output mem_valid, mem_addr, mem_wdata
   );

   modport slave (
      output start, cfg_base, cfg_len,
      output src0_valid, src0_data, src1_valid, src1_data,
      output obuf_do, mem_ready,
      input  busy, done, src0_ready, src1_ready,
      input  obuf_enb, obuf_ld_wrn, obuf_di,
      input  mem_valid, mem_addr, mem_wdata
   );
endinterface

// File: rtl/al_accel_obuf_ctrl.sv
// rtl/al_accel_obuf_ctrl.sv - round-robin result collector writing words through an output buffer to memory
//
// Purpose: for a job of cfg_len words starting at cfg_base, repeatedly takes one
// word from source 0 or 1 (round-robin), loads it into the external output-buffer
// register, then issues a memory write of the register contents at
// base + index*ADDR_STRIDE. Pulses done once the last word is accepted.
// Ports:
//   clk     : clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : al_accel_obuf_ctrl_if.master (job control, sources, obuf, memory)
module al_accel_obuf_ctrl #(
   parameter int LEN_W       = 16,
   parameter int ADDR_STRIDE = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   al_accel_obuf_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_SRC = 2'd1,
      S_WRITE    = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t           state_q;
   logic             ptr_q;          // source preferred when both are valid
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic [31:0]      base_q;
   logic [31:0]      addr_q;
   logic             busy_q;
   logic             done_q;
   logic             mem_valid_q;

   logic             in_wait;
   logic             gnt0;
   logic             gnt1;
   logic             xfer;
   logic [31:0]      gnt_data;
   logic [LEN_W-1:0] cnt_d;
   logic [31:0]      addr_d;

   // Grant is decided purely from the valids and the pointer so ready can be
   // returned in the same cycle; it only takes effect inside WAIT_SRC.
   always_comb begin
      in_wait  = (state_q == S_WAIT_SRC);
      gnt0     = bus.src0_valid && (!bus.src1_valid || !ptr_q);
      gnt1     = bus.src1_valid && (!bus.src0_valid ||  ptr_q);
      xfer     = in_wait && (gnt0 || gnt1);
      gnt_data = gnt0 ? bus.src0_data : bus.src1_data;
      cnt_d    = cnt_q + LEN_W'(1);
      // Address wraps modulo 2^32 by construction of the 32-bit sum.
      addr_d   = base_q + (32'(cnt_q) * 32'(ADDR_STRIDE));
   end

   assign bus.src0_ready  = in_wait && gnt0;
   assign bus.src1_ready  = in_wait && gnt1;
   assign bus.obuf_enb    = xfer;
   assign bus.obuf_ld_wrn = xfer;
   assign bus.obuf_di     = xfer ? gnt_data : 32'h0;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.mem_valid   = mem_valid_q;
   assign bus.mem_addr    = addr_q;
   // The buffer register holds the word loaded on the transfer edge and does
   // not change while WRITE waits, so wdata is stable under back-pressure.
   assign bus.mem_wdata   = mem_valid_q ? bus.obuf_do : 32'h0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         ptr_q       <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         base_q      <= 32'h0;
         addr_q      <= 32'h0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (bus.cfg_len != '0) begin
                     base_q  <= bus.cfg_base;
                     len_q   <= bus.cfg_len;
                     cnt_q   <= '0;
                     state_q <= S_WAIT_SRC;
                  end else begin
                     // Empty job: report completion without touching memory.
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end

            S_WAIT_SRC: begin
               if (xfer) begin
                  ptr_q       <= gnt0;   // point at the source not granted
                  addr_q      <= addr_d;
                  mem_valid_q <= 1'b1;
                  state_q     <= S_WRITE;
               end
            end

            S_WRITE: begin
               if (bus.mem_ready) begin
                  mem_valid_q <= 1'b0;
                  cnt_q       <= cnt_d;
                  if (cnt_d == len_q) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_WAIT_SRC;
                  end
               end
            end

            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy_q      <= 1'b0;
               mem_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_al_accel_obuf_ctrl.sv
// tb/tb_al_accel_obuf_ctrl.sv - self-checking bench for al_accel_obuf_ctrl
module tb_al_accel_obuf_ctrl;
   localparam int LEN_W = 16;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   int n_cmp;
   int n_fail;

   al_accel_obuf_ctrl_if #(.LEN_W(LEN_W)) bus ();
   al_accel_obuf_ctrl #(.LEN_W(LEN_W), .ADDR_STRIDE(4)) dut (
      .clk(clk), .resetn(resetn), .bus(bus));

   // Narrow instance for the full-length boundary job.
   al_accel_obuf_ctrl_if #(.LEN_W(6)) sbus ();
   al_accel_obuf_ctrl #(.LEN_W(6), .ADDR_STRIDE(8)) sdut (
      .clk(clk), .resetn(resetn), .bus(sbus));

   // Output-buffer register models.
   logic [31:0] obuf_q  = 32'h0;
   logic [31:0] sobuf_q = 32'h0;
   always @(posedge clk) begin
      if (bus.obuf_enb && bus.obuf_ld_wrn) obuf_q <= bus.obuf_di;
      if (sbus.obuf_enb && sbus.obuf_ld_wrn) sobuf_q <= sbus.obuf_di;
   end
   assign bus.obuf_do  = obuf_q;
   assign sbus.obuf_do = sobuf_q;

   typedef struct {
      logic v0, v1, r0, r1, mv, mr, done, busy, enb;
      logic [31:0] d0, d1, addr, wdata, di;
   } cyc_t;

   cyc_t        tr[$];
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          timed_out;

   task automatic idle_inputs();
      bus.start = 1'b0; bus.cfg_base = 32'h0; bus.cfg_len = '0;
      bus.src0_valid = 1'b0; bus.src0_data = 32'h0;
      bus.src1_valid = 1'b0; bus.src1_data = 32'h0;
      bus.mem_ready = 1'b0;
      sbus.start = 1'b0; sbus.cfg_base = 32'h0; sbus.cfg_len = '0;
      sbus.src0_valid = 1'b0; sbus.src0_data = 32'h0;
      sbus.src1_valid = 1'b0; sbus.src1_data = 32'h0;
      sbus.mem_ready = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // Drives one job and records every cycle into tr; does no checking.
   task automatic run_job(input logic [31:0] base, input logic [LEN_W-1:0] len,
                          input int p0, input int p1, input int pr,
                          input int stall, input int poke, input int max_cyc);
      bit   pres0 = 1'b0;
      bit   pres1 = 1'b0;
      int   stall_left = stall;
      bit   done_seen = 1'b0;
      cyc_t c;
      tr.delete();
      timed_out = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.cfg_base = base; bus.cfg_len = len;
      bus.src0_valid = 1'b0; bus.src1_valid = 1'b0; bus.mem_ready = 1'b0;
      for (int n = 0; n < max_cyc; n++) begin
         @(negedge clk);
         bus.start    = (n == poke);
         bus.cfg_base = ~base;
         bus.cfg_len  = len + LEN_W'(3);
         if (!pres0 && q0.size() > 0 && int'($urandom_range(99)) < p0) pres0 = 1'b1;
         if (!pres1 && q1.size() > 0 && int'($urandom_range(99)) < p1) pres1 = 1'b1;
         bus.src0_valid = pres0;
         bus.src0_data  = pres0 ? q0[0] : $urandom;
         bus.src1_valid = pres1;
         bus.src1_data  = pres1 ? q1[0] : $urandom;
         if (bus.mem_valid && stall_left > 0) begin
            bus.mem_ready = 1'b0;
            stall_left--;
         end else begin
            bus.mem_ready = (int'($urandom_range(99)) < pr);
         end
         #1;
         c.v0 = bus.src0_valid; c.v1 = bus.src1_valid;
         c.d0 = bus.src0_data;  c.d1 = bus.src1_data;
         c.r0 = bus.src0_ready; c.r1 = bus.src1_ready;
         c.mv = bus.mem_valid;  c.mr = bus.mem_ready;
         c.addr = bus.mem_addr; c.wdata = bus.mem_wdata;
         c.done = bus.done;     c.busy = bus.busy;
         c.enb = bus.obuf_enb;  c.di = bus.obuf_di;
         tr.push_back(c);
         if (c.r0) begin pres0 = 1'b0; void'(q0.pop_front()); end
         if (c.r1) begin pres1 = 1'b0; void'(q1.pop_front()); end
         if (done_seen) break;
         if (c.done) done_seen = 1'b1;
      end
      if (!done_seen) timed_out = 1;
      bus.start = 1'b0; bus.src0_valid = 1'b0; bus.src1_valid = 1'b0; bus.mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      bus.start = 1'b1; bus.cfg_len = 16'd5; bus.cfg_base = 32'h1234;
      bus.src0_valid = 1'b1; bus.src1_valid = 1'b1; bus.mem_ready = 1'b1;
      bus.src0_data = 32'hAAAA; bus.src1_data = 32'hBBBB;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.busy, bus.done, bus.src0_ready, bus.src1_ready, bus.obuf_enb, bus.obuf_ld_wrn, bus.mem_valid} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0000000", {bus.busy, bus.done, bus.src0_ready, bus.src1_ready, bus.obuf_enb, bus.obuf_ld_wrn, bus.mem_valid});
      end
      n_cmp++;
      if ((bus.obuf_di | bus.mem_addr | bus.mem_wdata) !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: got di=%h addr=%h wdata=%h expected 0", bus.obuf_di, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      bus.start = 1'b0;
      resetn = 1'b1;
      // Valid sources while idle must not be consumed.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({bus.src0_ready, bus.src1_ready, bus.obuf_enb, bus.busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_no_ready: got %b expected 0000", {bus.src0_ready, bus.src1_ready, bus.obuf_enb, bus.busy});
         end
      end
      idle_inputs();
   endtask

   task automatic test_single_source();
      logic [31:0] ea[$];
      logic [31:0] ed[$];
      int nd = 0;
      int first_mv = -1;
      q0 = '{32'hA, 32'hB, 32'hC}; q1.delete();
      run_job(32'h1000, 16'd3, 100, 0, 100, 0, -1, 100);
      foreach (tr[i]) begin
         if (tr[i].mv && tr[i].mr) begin ea.push_back(tr[i].addr); ed.push_back(tr[i].wdata); end
         if (tr[i].done) nd++;
         if (tr[i].mv && first_mv < 0) first_mv = i;
      end
      n_cmp++;
      if (timed_out != 0 || ea.size() != 3) begin
         n_fail++;
         $display("FAIL single_count: got %0d writes (timeout=%0d) expected 3", ea.size(), timed_out);
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ea[k] !== 32'h1000 + 32'(k) * 4 || ed[k] !== 32'hA + 32'(k)) begin
               n_fail++;
               $display("FAIL single_write%0d: got (%h,%h) expected (%h,%h)", k, ea[k], ed[k], 32'h1000 + 32'(k) * 4, 32'hA + 32'(k));
            end
         end
      end
      n_cmp++;
      if (first_mv != 1) begin
         n_fail++;
         $display("FAIL single_latency: got first mem_valid at cycle %0d expected 1", first_mv);
      end
      n_cmp++;
      if (nd != 1 || tr[tr.size()-1].busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: got done=%0d busy_after=%b expected 1,0", nd, tr[tr.size()-1].busy);
      end
   endtask

   task automatic test_round_robin();
      int          gs[$];
      logic [31:0] wd[$];
      int          eg[4] = '{0, 1, 0, 1};
      logic [31:0] ew[4] = '{32'h100, 32'h200, 32'h101, 32'h201};
      apply_reset();
      q0 = '{32'h100, 32'h101, 32'h102, 32'h103};
      q1 = '{32'h200, 32'h201, 32'h202, 32'h203};
      run_job(32'h0, 16'd4, 100, 100, 100, 0, -1, 100);
      foreach (tr[i]) begin
         if (tr[i].r0) gs.push_back(0);
         if (tr[i].r1) gs.push_back(1);
         if (tr[i].mv && tr[i].mr) wd.push_back(tr[i].wdata);
      end
      n_cmp++;
      if (timed_out != 0 || gs.size() != 4 || wd.size() != 4) begin
         n_fail++;
         $display("FAIL rr_count: got grants=%0d writes=%0d expected 4,4", gs.size(), wd.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (gs[k] != eg[k] || wd[k] !== ew[k]) begin
               n_fail++;
               $display("FAIL rr_grant%0d: got src%0d data %h expected src%0d data %h", k, gs[k], wd[k], eg[k], ew[k]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int fi = -1;
      apply_reset();
      q0 = '{32'h55}; q1 = '{32'h66};
      run_job(32'h5000, 16'd1, 100, 100, 100, 5, -1, 60);
      foreach (tr[i]) if (tr[i].mv && fi < 0) fi = i;
      n_cmp++;
      if (fi < 0 || fi + 5 >= tr.size()) begin
         n_fail++;
         $display("FAIL bp_window: got first mem_valid at %0d of %0d cycles expected room for 6", fi, tr.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (!(tr[fi+k].mv === 1'b1 && tr[fi+k].mr === 1'b0 && tr[fi+k].addr === 32'h5000 &&
                  tr[fi+k].wdata === 32'h55 && tr[fi+k].r0 === 1'b0 && tr[fi+k].r1 === 1'b0)) begin
               n_fail++;
               $display("FAIL bp_stall%0d: got mv=%b addr=%h wdata=%h r0=%b r1=%b expected 1 5000 55 0 0",
                        k, tr[fi+k].mv, tr[fi+k].addr, tr[fi+k].wdata, tr[fi+k].r0, tr[fi+k].r1);
            end
         end
         n_cmp++;
         if (tr[fi+5].mv !== 1'b1 || tr[fi+5].mr !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got mv=%b mr=%b expected 1,1", tr[fi+5].mv, tr[fi+5].mr);
         end
      end
      q1.delete();
   endtask

   task automatic test_zero_len();
      int nmv = 0;
      q0 = '{32'h9}; q1 = '{32'h8};
      run_job(32'h7000, 16'd0, 100, 100, 100, 0, -1, 20);
      foreach (tr[i]) if (tr[i].mv) nmv++;
      n_cmp++;
      if (timed_out != 0 || tr.size() != 2 || tr[0].done !== 1'b1 || tr[0].busy !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_done: got cycles=%0d done0=%b busy0=%b expected 2,1,1", tr.size(), tr[0].done, tr[0].busy);
      end
      n_cmp++;
      if (nmv != 0 || tr[tr.size()-1].busy !== 1'b0 || tr[tr.size()-1].done !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_nowrite: got mem_valid cycles=%0d last busy=%b expected 0,0", nmv, tr[tr.size()-1].busy);
      end
      q0.delete(); q1.delete();
   endtask

   task automatic test_start_ignored();
      logic [31:0] ea[$];
      q0 = '{32'h1, 32'h2}; q1.delete();
      run_job(32'h2000, 16'd2, 100, 0, 100, 0, 1, 100);
      foreach (tr[i]) if (tr[i].mv && tr[i].mr) ea.push_back(tr[i].addr);
      n_cmp++;
      if (timed_out != 0 || ea.size() != 2) begin
         n_fail++;
         $display("FAIL restart_count: got %0d writes expected 2", ea.size());
      end else begin
         n_cmp++;
         if (ea[0] !== 32'h2000 || ea[1] !== 32'h2004) begin
            n_fail++;
            $display("FAIL restart_addr: got %h,%h expected 2000,2004", ea[0], ea[1]);
         end
      end
   endtask

   task automatic test_addr_wrap();
      logic [31:0] ea[$];
      q0 = '{32'h11, 32'h22}; q1.delete();
      run_job(32'hFFFF_FFFC, 16'd2, 100, 0, 100, 0, -1, 100);
      foreach (tr[i]) if (tr[i].mv && tr[i].mr) ea.push_back(tr[i].addr);
      n_cmp++;
      if (ea.size() != 2 || ea[0] !== 32'hFFFF_FFFC || ea[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_addr: got %0d writes first=%h expected 2 writes FFFFFFFC,00000000",
                  ea.size(), ea.size() > 0 ? ea[0] : 32'h0);
      end
   endtask

   task automatic test_reset_mid_job();
      int mv_seen = 0;
      int nmv = 0;
      int nd = 0;
      int nb = 0;
      logic [31:0] ea[$];
      logic [31:0] ed[$];
      @(negedge clk);
      bus.start = 1'b1; bus.cfg_base = 32'h3000; bus.cfg_len = 16'd4;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.src0_valid = 1'b1; bus.src0_data = 32'(n); bus.mem_ready = 1'b1;
         #1;
         if (bus.mem_valid) mv_seen++;
         if (mv_seen == 2) break;
      end
      n_cmp++;
      if (mv_seen != 2) begin
         n_fail++;
         $display("FAIL midrst_reach: got %0d writes before reset expected 2", mv_seen);
      end
      #1;
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({bus.busy, bus.done, bus.src0_ready, bus.src1_ready, bus.obuf_enb, bus.obuf_ld_wrn, bus.mem_valid} !== 7'b0 ||
          (bus.obuf_di | bus.mem_addr | bus.mem_wdata) !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got ctrl=%b addr=%h wdata=%h expected all 0",
                  {bus.busy, bus.done, bus.src0_ready, bus.src1_ready, bus.obuf_enb, bus.obuf_ld_wrn, bus.mem_valid},
                  bus.mem_addr, bus.mem_wdata);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         #1;
         if (bus.mem_valid) nmv++;
         if (bus.done) nd++;
         if (bus.busy) nb++;
      end
      n_cmp++;
      if (nmv != 0 || nd != 0 || nb != 0) begin
         n_fail++;
         $display("FAIL midrst_quiet: got mem_valid=%0d done=%0d busy=%0d cycles expected 0,0,0", nmv, nd, nb);
      end
      idle_inputs();
      q0 = '{32'h77}; q1.delete();
      run_job(32'h4000, 16'd1, 100, 0, 100, 0, -1, 50);
      foreach (tr[i]) if (tr[i].mv && tr[i].mr) begin ea.push_back(tr[i].addr); ed.push_back(tr[i].wdata); end
      n_cmp++;
      if (timed_out != 0 || ea.size() != 1 || ea[0] !== 32'h4000 || ed[0] !== 32'h77) begin
         n_fail++;
         $display("FAIL midrst_restart: got %0d writes expected 1 write (4000,77)", ea.size());
      end
   endtask

   task automatic test_max_len();
      int k = 0;
      int nw = 0;
      int nd = 0;
      @(negedge clk);
      sbus.start = 1'b1; sbus.cfg_base = 32'h100; sbus.cfg_len = 6'h3F;
      sbus.src0_valid = 1'b1; sbus.src0_data = 32'hD000; sbus.mem_ready = 1'b1;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         sbus.start = 1'b0;
         sbus.src0_data = 32'hD000 + 32'(k);
         #1;
         if (sbus.src0_ready) k++;
         if (sbus.mem_valid && sbus.mem_ready) begin
            n_cmp++;
            if (sbus.mem_addr !== 32'h100 + 32'(nw) * 8 || sbus.mem_wdata !== 32'hD000 + 32'(nw)) begin
               n_fail++;
               $display("FAIL maxlen_write%0d: got (%h,%h) expected (%h,%h)", nw, sbus.mem_addr, sbus.mem_wdata,
                        32'h100 + 32'(nw) * 8, 32'hD000 + 32'(nw));
            end
            nw++;
         end
         if (sbus.done) begin nd++; break; end
      end
      @(negedge clk);
      sbus.src0_valid = 1'b0;
      #1;
      n_cmp++;
      if (nw != 63 || nd != 1 || sbus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL maxlen_done: got writes=%0d done=%0d busy=%b expected 63,1,0", nw, nd, sbus.busy);
      end
      idle_inputs();
   endtask

   // Job-level reference: grants follow round-robin over the offered valids,
   // one write is outstanding per grant, addresses advance by 4 per write.
   task automatic test_random();
      int ptr_m = 0;
      apply_reset();
      for (int j = 0; j < 8; j++) begin
         logic [31:0]      base = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : $urandom;
         logic [LEN_W-1:0] len  = LEN_W'($urandom_range(10, 1));
         int  writes = 0;
         bit  outstanding = 1'b0;
         bit  done_due = 1'b0;
         bit  finished = 1'b0;
         logic [31:0] pend = 32'h0;
         q0.delete(); q1.delete();
         for (int i = 0; i < 12; i++) begin q0.push_back($urandom); q1.push_back($urandom); end
         run_job(base, len, int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
                 int'($urandom_range(100, 30)), 0, -1, 400);
         foreach (tr[i]) begin
            bit er0, er1, ed, waiting;
            ed       = done_due;
            done_due = 1'b0;
            waiting  = !finished && !outstanding && writes < int'(len);
            er0 = waiting && tr[i].v0 && (!tr[i].v1 || ptr_m == 0);
            er1 = waiting && tr[i].v1 && (!tr[i].v0 || ptr_m == 1);
            n_cmp++;
            if (tr[i].r0 !== er0 || tr[i].r1 !== er1 || tr[i].enb !== (er0 | er1) ||
                tr[i].di !== (er0 ? tr[i].d0 : (er1 ? tr[i].d1 : 32'h0))) begin
               n_fail++;
               $display("FAIL rand_grant j%0d c%0d: got r=%b%b enb=%b di=%h expected r=%b%b", j, i,
                        tr[i].r0, tr[i].r1, tr[i].enb, tr[i].di, er0, er1);
            end
            n_cmp++;
            if (tr[i].mv !== outstanding || tr[i].done !== ed || tr[i].busy !== !finished) begin
               n_fail++;
               $display("FAIL rand_ctrl j%0d c%0d: got mv=%b done=%b busy=%b expected %b %b %b", j, i,
                        tr[i].mv, tr[i].done, tr[i].busy, outstanding, ed, !finished);
            end
            if (outstanding) begin
               n_cmp++;
               if (tr[i].addr !== base + 32'(writes) * 4 || tr[i].wdata !== pend) begin
                  n_fail++;
                  $display("FAIL rand_write j%0d w%0d: got (%h,%h) expected (%h,%h)", j, writes,
                           tr[i].addr, tr[i].wdata, base + 32'(writes) * 4, pend);
               end
            end
            if (ed) finished = 1'b1;
            if (er0 || er1) begin
               pend = er0 ? tr[i].d0 : tr[i].d1;
               outstanding = 1'b1;
               ptr_m = er0 ? 1 : 0;
            end else if (outstanding && tr[i].mr) begin
               outstanding = 1'b0;
               writes++;
               if (writes == int'(len)) done_due = 1'b1;
            end
         end
         n_cmp++;
         if (timed_out != 0 || writes != int'(len)) begin
            n_fail++;
            $display("FAIL rand_job%0d: got writes=%0d timeout=%0d expected %0d,0", j, writes, timed_out, len);
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_single_source();
      test_round_robin();
      test_backpressure();
      test_zero_len();
      test_start_ignored();
      test_addr_wrap();
      test_reset_mid_job();
      test_max_len();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish within 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/al_accel_obuf_ctrl.md
AL_ACCEL_OBUF_CTRL -- requirements
Module: al_accel_obuf_ctrl

Interface
REQ-001 Parameter LEN_W, 16: width of the transfer-length field and the word counter.
REQ-002 Parameter ADDR_STRIDE, 4: byte increment of mem_addr per written word.
REQ-003 clk  in  1  single clock; all state is updated on the rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle pulse that begins a job; ignored unless the block is IDLE.
REQ-006 cfg_base  in  32  byte address of the first word, sampled on an accepted start.
REQ-007 cfg_len  in  LEN_W  number of words in the job, sampled on an accepted start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when a job completes.
REQ-010 src0_valid / src0_data / src0_ready  in 1 / in 32 / out 1  result source 0, valid/ready handshake.
REQ-011 src1_valid / src1_data / src1_ready  in 1 / in 32 / out 1  result source 1, same protocol as source 0.
REQ-012 obuf_enb / obuf_ld_wrn / obuf_di  out 1 / out 1 / out 32  drive the enable, load and data inputs of the output-buffer register.
REQ-013 obuf_do  in  32  current contents of the output-buffer register.
REQ-014 mem_valid / mem_addr / mem_wdata  out 1 / out 32 / out 32  memory write request.
REQ-015 mem_ready  in  1  memory accepts the write when mem_valid && mem_ready.

Function
REQ-016 The FSM SHALL have four states: IDLE, WAIT_SRC, WRITE and DONE.
REQ-017 IDLE: on start with cfg_len!=0 the block SHALL latch base and len, clear cnt, and go to WAIT_SRC.
REQ-018 IDLE: on start with cfg_len==0 the block SHALL go to DONE, so done pulses on the next cycle and no memory write is issued.
REQ-019 srcN_ready SHALL be asserted only in WAIT_SRC, only for the granted source, and only when that source's valid is high (combinational from the valids and the priority pointer).
REQ-020 Arbitration SHALL be round-robin:
- If both sources are valid, the source named by the priority pointer ptr is granted.
- If only one source is valid, that source is granted.
- After every grant, ptr SHALL point to the source that was not granted.
REQ-021 In the transfer cycle, obuf_enb=1, obuf_ld_wrn=1 and obuf_di=granted data, so the register loads on that edge; the FSM then goes to WRITE.
REQ-022 Outside the transfer cycle, obuf_enb=0, obuf_ld_wrn=0 and obuf_di=0.
REQ-023 WRITE: mem_valid=1, mem_addr=base+cnt*ADDR_STRIDE (modulo 2^32), mem_wdata=obuf_do.
REQ-024 mem_addr and mem_wdata SHALL stay stable while mem_valid is high and mem_ready is low.
REQ-025 Latency: a source transfer at edge N SHALL produce mem_valid high in the cycle following edge N.
REQ-026 On mem_ready in WRITE the block SHALL increment cnt, then go to DONE if the new cnt equals len, otherwise to WAIT_SRC.
REQ-027 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE; busy is high in DONE.
REQ-028 A start pulse in any state other than IDLE SHALL be ignored, with no change to the latched configuration.
REQ-029 A source whose valid is high outside WAIT_SRC SHALL see ready=0 and SHALL NOT be consumed.
REQ-030 A job of cfg_len = 2^LEN_W-1 SHALL complete without the counter wrapping early.

Reset
REQ-031 While resetn=0, independent of clk:
- state=IDLE, ptr=0, cnt=0, and base and len are cleared to 0;
- busy, done, src0_ready, src1_ready, obuf_enb, obuf_ld_wrn and mem_valid are 0;
- obuf_di, mem_addr and mem_wdata are 0.
REQ-032 Reset asserted mid-job SHALL abandon the job: no done pulse and no further memory request after release.
REQ-033 The first start after reset release SHALL behave as in REQ-017 and REQ-018.

Verification
REQ-034 Single source, base=0x1000, len=3, src0 supplies 0xA, 0xB, 0xC, mem_ready always 1 -> writes (0x1000,0xA), (0x1004,0xB), (0x1008,0xC), then done high for one cycle, then busy low.
REQ-035 Both sources valid continuously, len=4 -> grants in order src0, src1, src0, src1, and each granted datum appears on mem_wdata.
REQ-036 mem_ready held low for 5 cycles in WRITE -> mem_valid, mem_addr and mem_wdata are constant for those cycles, and src0_ready and src1_ready stay 0.
REQ-037 start with cfg_len=0 -> done pulses on the next cycle and mem_valid is never asserted.
REQ-038 resetn pulsed low during the second WRITE of a len=4 job -> all outputs are 0 immediately, with no done pulse and no mem_valid until the next start.
REQ-039 base=0xFFFFFFFC, len=2 -> write addresses 0xFFFFFFFC then 0x00000000.
